// File: rtl/border_collision_ctrl_pkg.sv
// Shared definitions for the border collision reporter: direction bit layout,
// report FSM states and the default per-direction cooldown length.
package border_collision_ctrl_pkg;

    localparam int DIR_TOP    = 3;
    localparam int DIR_BOTTOM = 2;
    localparam int DIR_LEFT   = 1;
    localparam int DIR_RIGHT  = 0;

    localparam int COOLDOWN_DEFAULT = 3;

    typedef logic [3:0] border_dir_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } rpt_state_t;

    function automatic border_dir_t pack_dir(input logic top, input logic bottom,
                                             input logic left, input logic right);
        border_dir_t d;
        d             = '0;
        d[DIR_TOP]    = top;
        d[DIR_BOTTOM] = bottom;
        d[DIR_LEFT]   = left;
        d[DIR_RIGHT]  = right;
        return d;
    endfunction

endpackage

// File: rtl/border_collision_if.sv
// Report handshake between the collision controller (master) and its consumer
// (slave): valid/dir/overrun flow out, ack flows back.
interface border_collision_if;
    import border_collision_ctrl_pkg::*;

    logic        collision_valid;
    border_dir_t collision_dir;
    logic        collision_ack;
    logic        overrun;

    modport master (
        output collision_valid,
        output collision_dir,
        output overrun,
        input  collision_ack
    );

    modport slave (
        input  collision_valid,
        input  collision_dir,
        input  overrun,
        output collision_ack
    );

endinterface

// File: rtl/border_collision_ctrl_frame_cooldown.sv
// Per-direction frame cooldown counter: counts down one per frame boundary,
// reloads on a new report of its direction; active while nonzero.
module frame_cooldown
    import border_collision_ctrl_pkg::*;
#(
    parameter int FRAMES = COOLDOWN_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic load,
    output logic active
);

    logic [3:0] cnt;

    // A reload at a frame boundary wins over the decrement of that same boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (tick) begin
            if (load) begin
                cnt <= 4'(FRAMES);
            end else if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign active = (cnt != 4'd0);

endmodule

// File: rtl/border_collision_ctrl.sv
// Collects ball/border hits per frame and reports them once per frame close; report
// appears 1 cycle after startOfFrame and is held until acked, later reports merge (overrun).
module border_collision_ctrl
    import border_collision_ctrl_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = COOLDOWN_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                startOfFrame,
    input  logic                draw_ball,
    input  logic                draw_top_boarder,
    input  logic                draw_bottom_boarder,
    input  logic                draw_left_boarder,
    input  logic                draw_right_boarder,
    border_collision_if.master  rpt
);

    border_dir_t hits;
    border_dir_t acc;
    border_dir_t frame_hits;
    border_dir_t mask;
    border_dir_t new_dir;
    rpt_state_t  state;

    always_comb begin
        hits = pack_dir(draw_top_boarder, draw_bottom_boarder,
                        draw_left_boarder, draw_right_boarder) & {4{draw_ball}};
    end

    // Hits on the closing cycle itself still belong to the frame being closed.
    assign frame_hits = acc | hits;
    assign new_dir    = frame_hits & ~mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (startOfFrame) begin
            acc <= '0;
        end else begin
            acc <= acc | hits;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cooldown
        frame_cooldown #(
            .FRAMES (COOLDOWN_FRAMES)
        ) u_cooldown (
            .clk    (clk),
            .reset  (reset),
            .tick   (startOfFrame),
            .load   (new_dir[g]),
            .active (mask[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= ST_IDLE;
            rpt.collision_valid <= 1'b0;
            rpt.collision_dir   <= '0;
            rpt.overrun         <= 1'b0;
        end else begin
            rpt.overrun <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (startOfFrame && (new_dir != '0)) begin
                        state               <= ST_PENDING;
                        rpt.collision_valid <= 1'b1;
                        rpt.collision_dir   <= new_dir;
                    end
                end
                ST_PENDING: begin
                    if (startOfFrame) begin
                        if (rpt.collision_ack) begin
                            // Old report consumed on this edge; the new frame stands alone.
                            if (new_dir != '0) begin
                                rpt.collision_dir <= new_dir;
                            end else begin
                                state               <= ST_IDLE;
                                rpt.collision_valid <= 1'b0;
                            end
                        end else if (new_dir != '0) begin
                            rpt.collision_dir <= rpt.collision_dir | new_dir;
                            rpt.overrun       <= 1'b1;
                        end
                    end else if (rpt.collision_ack) begin
                        state               <= ST_IDLE;
                        rpt.collision_valid <= 1'b0;
                    end
                end
                default: begin
                    state               <= ST_IDLE;
                    rpt.collision_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_border_collision_ctrl.sv
// Directed bench for border_collision_ctrl: expected report state queued per step,
// popped and asserted one cycle after the driving edge.
module tb_border_collision_ctrl;
    import border_collision_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic startOfFrame;
    logic draw_ball;
    logic t_flag, b_flag, l_flag, r_flag;

    border_collision_if bif();

    border_collision_ctrl #(
        .COOLDOWN_FRAMES (3)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .startOfFrame        (startOfFrame),
        .draw_ball           (draw_ball),
        .draw_top_boarder    (t_flag),
        .draw_bottom_boarder (b_flag),
        .draw_left_boarder   (l_flag),
        .draw_right_boarder  (r_flag),
        .rpt                 (bif)
    );

    localparam logic [3:0] F_TOP    = 4'b1000;
    localparam logic [3:0] F_BOTTOM = 4'b0100;
    localparam logic [3:0] F_LEFT   = 4'b0010;
    localparam logic [3:0] F_RIGHT  = 4'b0001;
    localparam logic [3:0] F_NONE   = 4'b0000;

    typedef struct packed {
        logic       v;
        logic [3:0] d;
        logic       o;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic push(input logic v, input logic [3:0] d, input logic o, input string tag);
        exp_t e;
        e.v = v;
        e.d = d;
        e.o = o;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        exp_t  e;
        string tag;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_empty: got no entry, want one");
            return;
        end
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        n_cmp++;
        assert (bif.collision_valid === e.v) else begin
            n_err++;
            $error("FAIL %s valid: got %b want %b", tag, bif.collision_valid, e.v);
        end
        n_cmp++;
        assert (bif.collision_dir === e.d) else begin
            n_err++;
            $error("FAIL %s dir: got %b want %b", tag, bif.collision_dir, e.d);
        end
        n_cmp++;
        assert (bif.overrun === e.o) else begin
            n_err++;
            $error("FAIL %s overrun: got %b want %b", tag, bif.overrun, e.o);
        end
    endtask

    task automatic cyc(input logic sof, input logic [3:0] flg, input logic ball, input logic ack);
        startOfFrame      = sof;
        {t_flag, b_flag, l_flag, r_flag} = flg;
        draw_ball         = ball;
        bif.collision_ack = ack;
        @(posedge clk);
        #1;
        startOfFrame      = 1'b0;
        {t_flag, b_flag, l_flag, r_flag} = 4'b0000;
        draw_ball         = 1'b0;
        bif.collision_ack = 1'b0;
    endtask

    // One drawing cycle, then a frame-close cycle (with optional hits and ack on it).
    task automatic frame(input logic [3:0] dflg, input logic dball, input logic [3:0] cflg,
                         input logic ack, input logic v, input logic [3:0] d, input logic o,
                         input string tag);
        cyc(1'b0, dflg, dball, 1'b0);
        push(v, d, o, tag);
        cyc(1'b1, cflg, |cflg, ack);
        check_out();
    endtask

    task automatic tick(input logic ack, input logic v, input logic [3:0] d, input logic o,
                        input string tag);
        push(v, d, o, tag);
        cyc(1'b0, F_NONE, 1'b0, ack);
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        startOfFrame      = 1'b0;
        draw_ball         = 1'b0;
        {t_flag, b_flag, l_flag, r_flag} = 4'b0000;
        bif.collision_ack = 1'b0;

        cyc(1'b0, F_NONE, 1'b0, 1'b0);
        push(1'b0, 4'b0000, 1'b0, "reset");
        cyc(1'b1, F_TOP, 1'b1, 1'b0);
        check_out();
        reset = 1'b0;

        frame(F_TOP, 1'b0, F_NONE, 1'b0, 1'b0, 4'b0000, 1'b0, "no_ball");
        frame(F_NONE, 1'b1, F_NONE, 1'b0, 1'b0, 4'b0000, 1'b0, "ball_only");

        frame(F_TOP, 1'b1, F_NONE, 1'b0, 1'b1, 4'b1000, 1'b0, "top_report");
        tick(1'b0, 1'b1, 4'b1000, 1'b0, "top_hold");
        tick(1'b1, 1'b0, 4'b1000, 1'b0, "top_ack");

        frame(F_LEFT, 1'b1, F_NONE, 1'b0, 1'b1, 4'b0010, 1'b0, "left_report");
        frame(F_NONE, 1'b0, F_RIGHT, 1'b0, 1'b1, 4'b0011, 1'b1, "merge");
        tick(1'b0, 1'b1, 4'b0011, 1'b0, "overrun_once");

        frame(F_NONE, 1'b0, F_BOTTOM, 1'b1, 1'b1, 4'b0100, 1'b0, "ack_with_sof");
        tick(1'b1, 1'b0, 4'b0100, 1'b0, "ack_with_sof_done");

        frame(F_TOP, 1'b1, F_NONE, 1'b0, 1'b1, 4'b1000, 1'b0, "cd_report");
        tick(1'b1, 1'b0, 4'b1000, 1'b0, "cd_ack");
        frame(F_TOP, 1'b1, F_NONE, 1'b0, 1'b0, 4'b1000, 1'b0, "cd_mask1");
        frame(F_TOP, 1'b1, F_NONE, 1'b0, 1'b0, 4'b1000, 1'b0, "cd_mask2");
        frame(F_TOP, 1'b1, F_NONE, 1'b0, 1'b0, 4'b1000, 1'b0, "cd_mask3");
        frame(F_TOP, 1'b1, F_NONE, 1'b0, 1'b1, 4'b1000, 1'b0, "cd_expired");
        tick(1'b1, 1'b0, 4'b1000, 1'b0, "cd_ack2");

        frame(F_TOP | F_BOTTOM | F_RIGHT, 1'b1, F_NONE, 1'b0, 1'b1, 4'b0101, 1'b0, "corner");

        reset = 1'b1;
        push(1'b0, 4'b0000, 1'b0, "reset_pending");
        cyc(1'b0, F_NONE, 1'b0, 1'b0);
        check_out();
        reset = 1'b0;

        frame(F_TOP, 1'b1, F_NONE, 1'b0, 1'b1, 4'b1000, 1'b0, "post_reset_top");
        frame(F_NONE, 1'b0, F_NONE, 1'b0, 1'b1, 4'b1000, 1'b0, "pending_empty");
        frame(F_TOP, 1'b1, F_NONE, 1'b0, 1'b1, 4'b1000, 1'b0, "pending_masked");
        frame(F_NONE, 1'b0, F_NONE, 1'b1, 1'b0, 4'b1000, 1'b0, "ack_sof_empty");
        tick(1'b1, 1'b0, 4'b1000, 1'b0, "idle_ack_ignored");

        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/border_collision_ctrl.md
BORDER_COLLISION_CTRL -- requirements
Module: border_collision_ctrl

Interface
REQ-001 The block SHALL have parameter COOLDOWN_FRAMES, default 3, range 0..15: frames a reported direction stays masked after reporting; 0 disables masking.
REQ-002 The block SHALL have port clk, input, 1, the single system clock.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port startOfFrame, input, 1, one-cycle pulse marking the frame boundary.
REQ-005 The block SHALL have port draw_ball, input, 1, ball pixel drawn this cycle, aligned with the border flags.
REQ-006 The block SHALL have ports draw_top_boarder, draw_bottom_boarder, draw_left_boarder, draw_right_boarder, input, 1 each, registered border-pixel flags from the background renderer.
REQ-007 The block SHALL have port collision_ack, input, 1, consumer accepts the pending report.
REQ-008 The block SHALL have port collision_valid, output, 1, a report is pending.
REQ-009 The block SHALL have port collision_dir, output, 4, {top,bottom,left,right} hit bits of the pending report.
REQ-010 The block SHALL have port overrun, output, 1, one-cycle pulse when a new report merges into an unacknowledged one.

Function
REQ-011 Every cycle with startOfFrame low, acc SHALL become acc OR ({top,bottom,left,right} AND draw_ball).
REQ-012 A cycle with startOfFrame high SHALL close the frame: new = (acc OR this cycle's hits) AND NOT mask, where mask bit = cooldown counter nonzero; acc SHALL clear to 0 in the same cycle.
REQ-013 The FSM SHALL have two states: IDLE (collision_valid=0) and PENDING (collision_valid=1).
REQ-014 In IDLE, a frame close with new!=0 SHALL load collision_dir=new and enter PENDING; collision_valid rises in the next cycle (latency 1 from startOfFrame).
REQ-015 In IDLE, a frame close with new==0 SHALL stay in IDLE with collision_dir unchanged.
REQ-016 In PENDING, collision_ack high with no frame close SHALL return to IDLE next cycle; collision_dir SHALL hold its value.
REQ-017 In PENDING, a frame close with new!=0 and collision_ack low SHALL set collision_dir to collision_dir OR new, stay PENDING, and pulse overrun for one cycle.
REQ-018 In PENDING, a frame close with collision_ack high in the same cycle SHALL treat the old report as consumed: new!=0 loads collision_dir=new and stays PENDING with no overrun; new==0 goes to IDLE.
REQ-019 collision_dir SHALL be stable while collision_valid is high, except when merged per REQ-017.
REQ-020 collision_ack in IDLE SHALL be ignored.
REQ-021 At each frame close, a nonzero cooldown counter SHALL decrement by 1. A counter whose bit is set in new SHALL load COOLDOWN_FRAMES; this load takes priority over the decrement.
REQ-022 The mask used in REQ-012 SHALL be the counter value before that cycle's update.
REQ-023 Multiple directions in one frame, such as corner hits, SHALL all be reported and SHALL each start their own cooldown.

Reset
REQ-024 When reset is high at a clock edge, the block SHALL go to IDLE with acc=0, all cooldown counters=0, collision_valid=0, collision_dir=4'b0000 and overrun=0; reset overrides all other inputs, including mid-report.

Structure
REQ-025 Shared package defines SHALL hold the direction bit-index constants (DIR_TOP=3, DIR_BOTTOM=2, DIR_LEFT=1, DIR_RIGHT=0), typedef border_dir_t (logic [3:0]) and the default cooldown constant.
REQ-026 The per-direction counter SHALL be one sub-module, frame_cooldown, instantiated 4 times with inputs tick, load and reset and output active.

Verification
REQ-027 Scenario: draw_ball with top flag at one pixel, then startOfFrame -> collision_valid=1 one cycle later, collision_dir=4'b1000; ack -> valid=0 the next cycle.
REQ-028 Scenario: left hit in frame N and no ack, then right hit in frame N+1 -> collision_dir=4'b0011, overrun pulses once, valid stays 1.
REQ-029 Scenario: COOLDOWN_FRAMES=3, top hit reported and acked, top hit in each of the next frames -> frames N+1..N+3 report nothing; frame N+4 reports 4'b1000.
REQ-030 Scenario: collision_ack and startOfFrame in the same cycle with bottom hit -> collision_dir=4'b0100, valid stays 1, overrun=0.
REQ-031 Scenario: border flag high with draw_ball=0 for a full frame -> no report.
REQ-032 Scenario: reset asserted while PENDING with cooldowns active -> next cycle valid=0 and dir=0; an immediate top hit is reported with no masking.
